// File: rtl/datapath_pkg.sv
// datapath_pkg: data width and ALU opcode constants shared by the datapath and its ALU
package datapath_pkg;
  localparam int W = 32;
  localparam logic [4:0] OP_INC  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
endpackage

// File: rtl/datapath_alu.sv
// alu: combinational 64-bit result from A (Y register), B (bus) and a 5-bit opcode
//   A, B   : 32-bit operands
//   op     : opcode from datapath_pkg
//   result : high word used only by mul (upper product) and div (remainder)
module alu
  import datapath_pkg::*;
(
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [4:0]     op,
  output logic [2*W-1:0] result
);
  logic [4:0] s;
  assign s = B[4:0];
  always_comb begin
    result = '0;
    case (op)
      OP_INC:  result[W-1:0] = B + 1'b1;
      OP_ADD:  result[W-1:0] = A + B;
      OP_SUB:  result[W-1:0] = A - B;
      OP_SHR:  result[W-1:0] = A >> s;
      OP_SHRA: result[W-1:0] = $signed(A) >>> s;
      OP_SHL:  result[W-1:0] = A << s;
      // a shift of 32 yields 0, so a rotate by 0 returns A unchanged
      OP_ROR:  result[W-1:0] = (A >> s) | (A << (6'd32 - {1'b0, s}));
      OP_ROL:  result[W-1:0] = (A << s) | (A >> (6'd32 - {1'b0, s}));
      OP_AND:  result[W-1:0] = A & B;
      OP_OR:   result[W-1:0] = A | B;
      OP_MUL:  result = $signed({{W{A[W-1]}}, A}) * $signed({{W{B[W-1]}}, B});
      OP_DIV:  result = (B == '0) ? '0 : {W'($signed(A) % $signed(B)), W'($signed(A) / $signed(B))};
      OP_NEG:  result[W-1:0] = -B;
      OP_NOT:  result[W-1:0] = ~B;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/datapath.sv
// datapath: single-bus register datapath with R0/R4/R5/PC/IR/MAR/MDR/Y/Z and an ALU
//   clk, clr        : rising-edge clock, asynchronous active-high clear
//   *_in            : register load enables from the bus (MDR may load Mdatain when Read)
//   *_out           : bus drive selects, priority MDR > Zlow > PC > R5 > R4
//   Read, Mdatain   : memory read select and data for MDR
//   alu_instruction : ALU opcode, A = Y, B = bus, Z_in latches the 64-bit result
//   *_Data          : register views and the bus itself
module datapath
  import datapath_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         R0_in,
  input  logic         R4_in,
  input  logic         R5_in,
  input  logic         PC_in,
  input  logic         IR_in,
  input  logic         MAR_in,
  input  logic         MDR_in,
  input  logic         Y_in,
  input  logic         Z_in,
  input  logic         R4_out,
  input  logic         R5_out,
  input  logic         PC_out,
  input  logic         Zlow_out,
  input  logic         MDR_out,
  input  logic         Read,
  input  logic [W-1:0] Mdatain,
  input  logic [4:0]   alu_instruction,
  output logic [W-1:0] Bus_Data,
  output logic [W-1:0] R0_Data,
  output logic [W-1:0] R4_Data,
  output logic [W-1:0] R5_Data,
  output logic [W-1:0] PC_Data,
  output logic [W-1:0] IR_Data,
  output logic [W-1:0] MAR_Data,
  output logic [W-1:0] MDR_Data,
  output logic [W-1:0] Y_Data,
  output logic [W-1:0] Zhigh_Data,
  output logic [W-1:0] Zlow_Data
);
  logic [2*W-1:0] alu_result;
  always_comb
    Bus_Data = MDR_out  ? MDR_Data  :
               Zlow_out ? Zlow_Data :
               PC_out   ? PC_Data   :
               R5_out   ? R5_Data   :
               R4_out   ? R4_Data   : '0;
  alu u_alu (
    .A      (Y_Data),
    .B      (Bus_Data),
    .op     (alu_instruction),
    .result (alu_result)
  );
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      R0_Data    <= '0;
      R4_Data    <= '0;
      R5_Data    <= '0;
      PC_Data    <= '0;
      IR_Data    <= '0;
      MAR_Data   <= '0;
      MDR_Data   <= '0;
      Y_Data     <= '0;
      Zhigh_Data <= '0;
      Zlow_Data  <= '0;
    end else begin
      if (R0_in)  R0_Data  <= Bus_Data;
      if (R4_in)  R4_Data  <= Bus_Data;
      if (R5_in)  R5_Data  <= Bus_Data;
      if (PC_in)  PC_Data  <= Bus_Data;
      if (IR_in)  IR_Data  <= Bus_Data;
      if (MAR_in) MAR_Data <= Bus_Data;
      if (Y_in)   Y_Data   <= Bus_Data;
      if (MDR_in) MDR_Data <= Read ? Mdatain : Bus_Data;
      if (Z_in)   {Zhigh_Data, Zlow_Data} <= alu_result;
    end
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed scoreboard bench for datapath
module tb_datapath;
  import datapath_pkg::*;
  logic clk = 1'b0, clr;
  logic R0_in, R4_in, R5_in, PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in;
  logic R4_out, R5_out, PC_out, Zlow_out, MDR_out, Read;
  logic [31:0] Mdatain;
  logic [4:0]  alu_instruction;
  logic [31:0] Bus_Data, R0_Data, R4_Data, R5_Data, PC_Data, IR_Data, MAR_Data, MDR_Data, Y_Data, Zhigh_Data, Zlow_Data;
  localparam int S_BUS = 0, S_R0 = 1, S_R4 = 2, S_R5 = 3, S_PC = 4, S_IR = 5, S_MAR = 6, S_MDR = 7, S_Y = 8, S_ZH = 9, S_ZL = 10, S_IROP = 11;
  typedef struct {string tag; int sel; logic [31:0] exp;} item_t;
  item_t sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  datapath dut (
    .clk(clk), .clr(clr),
    .R0_in(R0_in), .R4_in(R4_in), .R5_in(R5_in), .PC_in(PC_in), .IR_in(IR_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .Y_in(Y_in), .Z_in(Z_in),
    .R4_out(R4_out), .R5_out(R5_out), .PC_out(PC_out), .Zlow_out(Zlow_out), .MDR_out(MDR_out),
    .Read(Read), .Mdatain(Mdatain), .alu_instruction(alu_instruction),
    .Bus_Data(Bus_Data), .R0_Data(R0_Data), .R4_Data(R4_Data), .R5_Data(R5_Data), .PC_Data(PC_Data),
    .IR_Data(IR_Data), .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .Y_Data(Y_Data),
    .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
  );
  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_BUS:   return Bus_Data;
      S_R0:    return R0_Data;
      S_R4:    return R4_Data;
      S_R5:    return R5_Data;
      S_PC:    return PC_Data;
      S_IR:    return IR_Data;
      S_MAR:   return MAR_Data;
      S_MDR:   return MDR_Data;
      S_Y:     return Y_Data;
      S_ZH:    return Zhigh_Data;
      S_ZL:    return Zlow_Data;
      default: return {27'd0, IR_Data[31:27]};
    endcase
  endfunction
  task automatic push(string t, int s, logic [31:0] v);
    sb.push_back('{t, s, v});
  endtask
  task automatic drain();
    item_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.sel);
      total++;
      assert (got === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
      end
    end
  endtask
  task automatic idle();
    {R0_in, R4_in, R5_in, PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in} = '0;
    {R4_out, R5_out, PC_out, Zlow_out, MDR_out, Read} = '0;
    alu_instruction = 5'b11111;
  endtask
  task automatic settle();
    #1;
    drain();
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    idle();
  endtask
  task automatic push_all_zero(string t);
    for (int i = 0; i <= S_ZL; i++) push(t, i, 32'd0);
  endtask
  task automatic load_mdr(logic [31:0] v);
    Mdatain = v; MDR_in = 1; Read = 1;
    push("mdr_read", S_MDR, v);
    tick();
  endtask
  task automatic alu_op(string t, logic [4:0] op, logic [31:0] zl, logic [31:0] zh);
    MDR_out = 1; Z_in = 1; alu_instruction = op;
    push({t, "_lo"}, S_ZL, zl);
    push({t, "_hi"}, S_ZH, zh);
    tick();
  endtask
  initial begin
    idle();
    Mdatain = '0;
    clr = 1;
    #2;
    push_all_zero("reset");
    drain();
    @(negedge clk) clr = 0;
    load_mdr(32'h0000FA92);
    MDR_out = 1; R4_in = 1;
    push("bus_mdr", S_BUS, 32'h0000FA92);
    settle();
    push("r4_load", S_R4, 32'h0000FA92);
    push("mdr_hold", S_MDR, 32'h0000FA92);
    tick();
    load_mdr(32'h000000FF);
    MDR_out = 1; R5_in = 1;
    push("r5_load", S_R5, 32'h000000FF);
    tick();
    R4_out = 1; Y_in = 1;
    push("y_load", S_Y, 32'h0000FA92);
    tick();
    R5_out = 1; Z_in = 1; alu_instruction = OP_ADD;
    push("add_lo", S_ZL, 32'h0000FB91);
    push("add_hi", S_ZH, 32'h0);
    tick();
    Zlow_out = 1; R0_in = 1;
    push("r0_load", S_R0, 32'h0000FB91);
    tick();
    PC_out = 1; MAR_in = 1; Z_in = 1; alu_instruction = OP_INC;
    push("mar_pc", S_MAR, 32'h0);
    push("inc_lo", S_ZL, 32'h1);
    tick();
    Zlow_out = 1; PC_in = 1;
    push("pc_inc", S_PC, 32'h1);
    tick();
    R4_out = 1; R5_out = 1;
    push("prio_r5_r4", S_BUS, 32'h000000FF);
    settle();
    PC_out = 1;
    push("prio_pc_r5", S_BUS, 32'h1);
    settle();
    MDR_out = 1; Zlow_out = 1;
    push("prio_mdr_zlow", S_BUS, 32'h000000FF);
    settle();
    idle();
    push("bus_idle", S_BUS, 32'h0);
    settle();
    R5_out = 1; R5_in = 1;
    push("self_load", S_R5, 32'h000000FF);
    tick();
    load_mdr(32'h18228000);
    MDR_out = 1; IR_in = 1;
    push("ir_load", S_IR, 32'h18228000);
    push("ir_opcode", S_IROP, 32'h3);
    tick();
    Mdatain = 32'hDEADBEEF; Read = 1;
    push("read_no_load", S_MDR, 32'h18228000);
    tick();
    load_mdr(32'hFFFFFFFE);
    MDR_out = 1; Y_in = 1;
    push("y_neg2", S_Y, 32'hFFFFFFFE);
    tick();
    load_mdr(32'h3);
    alu_op("mul", OP_MUL, 32'hFFFFFFFA, 32'hFFFFFFFF);
    alu_op("shra", OP_SHRA, 32'hFFFFFFFF, 32'h0);
    alu_op("shr", OP_SHR, 32'h1FFFFFFF, 32'h0);
    load_mdr(32'h7);
    MDR_out = 1; Y_in = 1;
    push("y_7", S_Y, 32'h7);
    tick();
    load_mdr(32'h2);
    alu_op("div", OP_DIV, 32'h3, 32'h1);
    alu_op("sub", OP_SUB, 32'h5, 32'h0);
    alu_op("shl", OP_SHL, 32'h1C, 32'h0);
    alu_op("ror", OP_ROR, 32'hC0000001, 32'h0);
    alu_op("rol", OP_ROL, 32'h1C, 32'h0);
    alu_op("and", OP_AND, 32'h2, 32'h0);
    alu_op("or", OP_OR, 32'h7, 32'h0);
    alu_op("neg", OP_NEG, 32'hFFFFFFFE, 32'h0);
    alu_op("undef", 5'b01100, 32'h0, 32'h0);
    load_mdr(32'h0);
    alu_op("div0", OP_DIV, 32'h0, 32'h0);
    alu_op("not", OP_NOT, 32'hFFFFFFFF, 32'h0);
    load_mdr(32'hFFFFFFFF);
    alu_op("inc_wrap", OP_INC, 32'h0, 32'h0);
    #2 clr = 1;
    #1;
    push_all_zero("clr_async");
    drain();
    Mdatain = 32'h55; MDR_in = 1; Read = 1;
    push("clr_override", S_MDR, 32'h0);
    tick();
    @(negedge clk) clr = 0;
    Mdatain = 32'h55; MDR_in = 1; Read = 1;
    push("post_clr_load", S_MDR, 32'h55);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; clr in 1, asynchronous active-high reset.
REQ-002 SHALL have load enables, each in 1, sampled at rising clk: R0_in, R4_in, R5_in, PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in.
REQ-003 SHALL have bus-drive selects, each in 1: R4_out, R5_out, PC_out, Zlow_out, MDR_out.
REQ-004 SHALL have Read in 1, which selects Mdatain, not Bus_Data, as the MDR load source.
REQ-005 SHALL have Mdatain in 32, memory read data, and alu_instruction in 5, ALU opcode.
REQ-006 SHALL have outputs, each out 32: Bus_Data, R0_Data, R4_Data, R5_Data, PC_Data, IR_Data, MAR_Data, MDR_Data, Y_Data, Zhigh_Data, Zlow_Data, each a direct register or bus view.

Function
REQ-007 SHALL drive Bus_Data combinationally from one source, priority MDR_out > Zlow_out > PC_out > R5_out > R4_out; none asserted -> 0.
REQ-008 SHALL load R0, R4, R5, PC, IR, MAR and Y from Bus_Data at rising clk when their _in is 1; otherwise hold.
REQ-009 SHALL load MDR at rising clk when MDR_in=1, from Mdatain if Read=1, else from Bus_Data; Read without MDR_in has no effect.
REQ-010 SHALL compute a combinational 64-bit ALU result from A=Y, B=Bus_Data, op=alu_instruction; Z_in=1 latches result[63:32] into Zhigh and result[31:0] into Zlow at rising clk.
REQ-011 SHALL implement opcode 00000 as increment, B+1; opcode 00011 as add, A+B.
REQ-012 SHALL implement opcode 00100 as sub, A-B.
REQ-013 SHALL implement shifts with amount B[4:0]: 00101 shr, logical right; 00110 shra, arithmetic right; 00111 shl; 01000 ror; 01001 rol, all on A.
REQ-014 SHALL implement 01010 as and, A&B; 01011 as or, A|B.
REQ-015 SHALL implement 01110 mul: signed 64-bit A*B.
REQ-016 SHALL implement 01111 div: signed, quotient to low word and remainder to high word; B=0 -> both words 0.
REQ-017 SHALL implement 10000 neg: -B; 10001 not: ~B.
REQ-018 SHALL set the high word to 0 for every op except mul/div; add/sub/inc wrap modulo 2^32, carry discarded.
REQ-019 SHALL produce result 0 for undefined opcodes.
REQ-020 SHALL, when a register both drives and loads the bus in the same cycle, load the pre-edge value, i.e. hold its value.
REQ-021 SHALL allow simultaneous loads of several registers from the same bus value in one cycle, e.g. MAR and Z from PC.
REQ-022 SHALL impose no internal latency beyond one clock edge per transfer; all outputs reflect register state immediately after the edge.

Reset
REQ-023 SHALL clear every register (R0, R4, R5, PC, IR, MAR, MDR, Y, Zhigh, Zlow) to 0 immediately on clr=1, independent of clk, and hold 0 while clr=1.
REQ-024 SHALL have clr override all load enables; loading resumes at the first rising clk after clr deasserts.

Structure
REQ-025 SHALL place opcode constants and the data width (32) in a shared package, datapath_pkg.
REQ-026 SHALL implement the ALU as one combinational sub-module, alu, with inputs A, B, op and a 64-bit result; all other registers live in datapath.

Verification
REQ-027 SHALL be verified with: MDR_in+Read, Mdatain=0xFA92; then MDR_out+R4_in -> MDR_Data=R4_Data=0x0000FA92.
REQ-028 SHALL be verified with: R4=0xFA92, R5=0xFF; R4_out+Y_in, then R5_out+Z_in, op 00011, then Zlow_out+R0_in -> Zlow_Data=R0_Data=0x0000FB91, Zhigh_Data=0.
REQ-029 SHALL be verified with: PC=0; PC_out+MAR_in+Z_in, op 00000 -> MAR_Data=0, Zlow_Data=1; then Zlow_out+PC_in -> PC_Data=1.
REQ-030 SHALL be verified with: Mdatain=0x18228000, MDR_in+Read, then MDR_out+IR_in -> IR_Data=0x18228000, IR_Data[31:27]=00011.
REQ-031 SHALL be verified with: Y=0xFFFFFFFE (-2), B=3, op 01110 -> Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFFA; op 01111 with Y=7, B=2 -> Zlow=3, Zhigh=1.
REQ-032 SHALL be verified with: clr pulsed mid-cycle after loads -> all _Data outputs 0 before next clk edge.
